stream_orchestrator: RTL and testbench
======================================

# stream_orchestrator

Shares one AXI-Stream master port between N snoop submodules (AR/AW/R/W/B channel snoopers), each of which presents valid/data/last/transaction-length and waits on a per-submodule ready. Performs round-robin arbitration, locks the grant for multi-beat submodule transactions, frames each transaction as one stream packet with TLAST, and owns the free-running timestamp counter distributed to all submodules.

## Interface
- N_SUB, 5, number of requesting submodules (2..8)
- DATA_WIDTH, 128, stream and submodule data width
- TIMER_WIDTH, 20, timestamp counter width
- SEL_WIDTH, 3, width of source index; must satisfy 2^SEL_WIDTH >= N_SUB

- clk  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- sub_valid  in  N_SUB  submodule i has a beat on offer
- sub_last  in  N_SUB  submodule i marks its final beat (consistency check only)
- sub_data  in  N_SUB*DATA_WIDTH  submodule i data at [i*DATA_WIDTH +: DATA_WIDTH]
- sub_length  in  N_SUB*6  submodule i transaction length in beats at [i*6 +: 6]
- sub_ready  out  N_SUB  one-hot or zero; beat of submodule i accepted when sub_valid[i] & sub_ready[i]
- timestamp  out  TIMER_WIDTH  free-running cycle counter to all submodules
- M_AXIS_tvalid  out  1  stream beat valid
- M_AXIS_tready  in  1  downstream ready
- M_AXIS_tdata  out  DATA_WIDTH  granted submodule data
- M_AXIS_tid  out  SEL_WIDTH  index of granted submodule
- M_AXIS_tlast  out  1  final beat of the submodule transaction
- protocol_err  out  1  sticky submodule framing error

## Operation
- State: IDLE, BURST. Registers: state, rr_ptr (SEL_WIDTH), lock_sel (SEL_WIDTH), beat_cnt (6), len_reg (6), timestamp, protocol_err.
- Effective length L = sub_length of the selected submodule; L=0 treated as 1.
- IDLE: combinational pick g = first i with sub_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo N_SUB. If none: tvalid=0, sub_ready=0. Else tvalid=1, tdata=data[g], tid=g, sub_ready=onehot(g) & M_AXIS_tready, tlast=(L==1).
- IDLE handshake (tvalid & tready): L==1 -> stay IDLE, rr_ptr <= (g+1) mod N_SUB. L>1 -> BURST, lock_sel <= g, len_reg <= L, beat_cnt <= 1.
- BURST: selection fixed to lock_sel regardless of other valids; tvalid=sub_valid[lock_sel]; sub_ready=onehot(lock_sel) & M_AXIS_tready; tlast=(beat_cnt==len_reg-1).
- BURST handshake: non-final -> beat_cnt+1. Final -> IDLE, rr_ptr <= (lock_sel+1) mod N_SUB.
- Locked submodule dropping valid mid-burst: tvalid=0, remain in BURST, counters hold.
- sub_ready never depends on sub_valid of another submodule; sub_valid must not depend on sub_ready (no combinational loop).
- protocol_err set on any handshake where sub_last of the selected submodule is 1 but tlast is 0; cleared only by reset. sub_last=0 on a final beat is legal (single-beat submodules drive last=0).
- timestamp increments by 1 every cycle, wraps 2^TIMER_WIDTH-1 -> 0.

## Timing
- Reset (async assert, sync to clk on release): state=IDLE, rr_ptr=0, lock_sel=0, beat_cnt=0, len_reg=0, timestamp=0, protocol_err=0. Outputs in reset: tvalid=0, sub_ready=0, tlast=0, tid=0, tdata=0.
- Zero-cycle arbitration latency: a sub_valid rising in IDLE with tready high is accepted same cycle.
- Back-to-back packets: new grant possible cycle after final beat; no bubble.
- tready low: tdata/tid/tlast stable while tvalid held (selection only changes on handshake or new valid in IDLE).
- Reset mid-burst: packet truncated without tlast; downstream responsible for recovery.
- Simultaneous requests: round-robin guarantees each valid submodule served within N_SUB transactions.

## Test plan
- Single request: sub_valid=00001, length 1, tready=1 -> one beat, tid=0, tlast=1, sub_ready=00001, rr_ptr=1.
- Contention: all 5 valid, length 1, tready=1 for 5 cycles from reset -> tid sequence 0,1,2,3,4, tlast every beat.
- Burst lock: sub 2 length 4 and sub 3 valid continuously -> tid=2 for 4 beats, tlast on 4th only, then tid=3.
- Backpressure/stall: tready toggling and sub 2 dropping valid mid 4-beat burst -> no grant change, beat_cnt holds, exactly 4 accepted beats.
- Framing error: sub 1 length 3 asserts sub_last on beat 2 -> protocol_err=1 and stays 1; length 0 request -> single beat with tlast=1.
- Reset and timer: assert resetn=0 mid-burst between edges -> outputs zero immediately; timestamp with TIMER_WIDTH=4 wraps 15 -> 0.

Source files
------------

// File: rtl/stream_orchestrator_if.sv
// Stream master bus shared by the orchestrator and its downstream sink.
interface stream_orchestrator_if #(
  parameter int DATA_WIDTH = 128,
  parameter int SEL_WIDTH  = 3
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [SEL_WIDTH-1:0]  tid;
  logic                  tlast;

  modport master (output tvalid, tdata, tid, tlast, input tready);
  modport slave  (input tvalid, tdata, tid, tlast, output tready);
endinterface

// File: rtl/stream_orchestrator.sv
// Round-robin arbiter that merges N snoop submodules onto one stream port,
// locking the grant for multi-beat transactions and framing each with tlast.
// Also owns the free-running timestamp shared with all submodules.
module stream_orchestrator #(
  parameter int N_SUB       = 5,
  parameter int DATA_WIDTH  = 128,
  parameter int TIMER_WIDTH = 20,
  parameter int SEL_WIDTH   = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_SUB-1:0]            sub_valid,
  input  logic [N_SUB-1:0]            sub_last,
  input  logic [N_SUB*DATA_WIDTH-1:0] sub_data,
  input  logic [N_SUB*6-1:0]          sub_length,
  output logic [N_SUB-1:0]            sub_ready,
  output logic [TIMER_WIDTH-1:0]      timestamp,
  output logic                        protocol_err,
  stream_orchestrator_if.master       m_axis
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   rr_q, rr_d, lock_q, lock_d;
  logic [5:0]             beat_q, beat_d, len_q, len_d;
  logic [TIMER_WIDTH-1:0] ts_q;
  logic                   err_q, err_d;

  logic [N_SUB-1:0][DATA_WIDTH-1:0] data_a;
  logic [N_SUB-1:0][5:0]            len_a;
  assign data_a = sub_data;
  assign len_a  = sub_length;

  logic                 found;
  logic [SEL_WIDTH-1:0] g, idx, sel;
  logic [5:0]           eff_len;
  logic                 tvalid_c, tlast_c, hs;

  function automatic logic [SEL_WIDTH-1:0] nxt(input logic [SEL_WIDTH-1:0] s);
    return (int'(s) == N_SUB - 1) ? '0 : s + 1'b1;
  endfunction

  // Round-robin pick: first valid requester starting at rr_q.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < N_SUB; k++) begin
      idx = SEL_WIDTH'((int'(rr_q) + k) % N_SUB);
      if (!found && sub_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  // Datapath selection and beat framing; a burst pins the mux to lock_q.
  always_comb begin
    sel      = (state_q == BURST) ? lock_q : g;
    eff_len  = (len_a[sel] == 6'd0) ? 6'd1 : len_a[sel];
    tvalid_c = 1'b0;
    tlast_c  = 1'b0;
    if (state_q == BURST) begin
      tvalid_c = sub_valid[lock_q];
      tlast_c  = (beat_q == len_q - 6'd1);
    end else begin
      tvalid_c = found;
      tlast_c  = (eff_len == 6'd1);
    end
    hs = tvalid_c & m_axis.tready;
  end

  // Outputs are forced to zero while reset is held, even mid-cycle.
  always_comb begin
    m_axis.tvalid = resetn & tvalid_c;
    m_axis.tlast  = resetn & tlast_c;
    m_axis.tid    = resetn ? sel : '0;
    m_axis.tdata  = resetn ? data_a[sel] : '0;
    sub_ready     = '0;
    if (resetn && m_axis.tready && (state_q == BURST || found))
      sub_ready = N_SUB'(1) << sel;
  end

  assign timestamp    = ts_q;
  assign protocol_err = err_q;

  // Next-state: grant/lock/release and beat counting on handshakes.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    beat_d  = beat_q;
    len_d   = len_q;
    err_d   = err_q | (hs & sub_last[sel] & ~tlast_c);
    case (state_q)
      IDLE: if (hs) begin
        if (eff_len == 6'd1) begin
          rr_d = nxt(g);
        end else begin
          state_d = BURST;
          lock_d  = g;
          len_d   = eff_len;
          beat_d  = 6'd1;
        end
      end
      BURST: if (hs) begin
        if (tlast_c) begin
          state_d = IDLE;
          rr_d    = nxt(lock_q);
        end else begin
          beat_d = beat_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers and free-running timestamp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      ts_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      ts_q    <= ts_q + 1'b1;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_stream_orchestrator.sv
// Self-checking bench: per-cycle vector table plus scoreboard of accepted beats.
module tb_stream_orchestrator;
  localparam int N  = 5;
  localparam int DW = 128;
  localparam int TW = 4;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [N-1:0]      sub_valid = '0, sub_last = '0, sub_ready;
  logic [N*DW-1:0]   sub_data = '0;
  logic [N*6-1:0]    sub_length = '0;
  logic [TW-1:0]     timestamp;
  logic              protocol_err;

  stream_orchestrator_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) m ();

  stream_orchestrator #(.N_SUB(N), .DATA_WIDTH(DW), .TIMER_WIDTH(TW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .resetn(resetn), .sub_valid(sub_valid), .sub_last(sub_last),
    .sub_data(sub_data), .sub_length(sub_length), .sub_ready(sub_ready),
    .timestamp(timestamp), .protocol_err(protocol_err), .m_axis(m)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    logic [N-1:0] v, l;
    logic         rdy;
    logic [29:0]  len;
    logic         e_v;
    logic [2:0]   e_id;
    logic [N-1:0] e_rdy;
    logic         e_last;
    logic         e_err;
  } vec_t;

  typedef struct {
    logic [2:0]    tid;
    logic          tlast;
    logic [DW-1:0] data;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];
  exp_t got;
  int   n_chk = 0, n_pass = 0, step = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, step);
  endtask

  function automatic logic [DW-1:0] dpat(input int i, input int k);
    return {4{8'(i + 1), 24'(k)}};
  endfunction

  function automatic logic [29:0] lens(input int a, b, c, d, e);
    return {6'(e), 6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic vec_t mk(input bit rst, input logic [N-1:0] v, l, input logic rdy,
                              input logic [29:0] len, input logic ev, input int id,
                              input logic [N-1:0] er, input logic el, input logic ee);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.rdy = rdy; t.len = len;
    t.e_v = ev; t.e_id = 3'(id); t.e_rdy = er; t.e_last = el; t.e_err = ee;
    return t;
  endfunction

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (resetn && m.tvalid && m.tready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: beat tid=%0d accepted, expected no beat", m.tid);
      end else begin
        got = sbq.pop_front();
        chk("sb_beat", {m.tid, m.tlast, m.tdata}, {got.tid, got.tlast, got.data});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0; sub_valid = '0; sub_last = '0; m.tready = 1'b0;
    @(negedge clk); #1;
    resetn = 1'b1;
    chk("rst_ts", 192'(timestamp), 192'(0));
    chk("rst_err", 192'(protocol_err), 192'(0));
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    @(posedge clk); #1;
    step++;
    sub_valid = t.v; sub_last = t.l; m.tready = t.rdy; sub_length = t.len;
    for (int i = 0; i < N; i++) sub_data[i*DW +: DW] = dpat(i, step);
    if (t.e_v && t.rdy) begin
      e.tid = t.e_id; e.tlast = t.e_last; e.data = dpat(int'(t.e_id), step);
      sbq.push_back(e);
    end
    @(negedge clk);
    chk("tvalid", 192'(m.tvalid), 192'(t.e_v));
    chk("sub_ready", 192'(sub_ready), 192'(t.e_rdy));
    chk("protocol_err", 192'(protocol_err), 192'(t.e_err));
    if (t.e_v) begin
      chk("tid", 192'(m.tid), 192'(t.e_id));
      chk("tlast", 192'(m.tlast), 192'(t.e_last));
      chk("tdata", 192'(m.tdata), 192'(dpat(int'(t.e_id), step)));
    end
  endtask

  initial begin
    m.tready = 1'b0;
    // Arbitration with single-beat requests, including length 0.
    tv.push_back(mk(1, 5'b11111, 5'b11111, 1, lens(1,1,1,1,1), 1, 0, 5'b00001, 1, 0));
    tv.push_back(mk(0, 5'b11111, 5'b00000, 1, lens(1,1,1,1,1), 1, 1, 5'b00010, 1, 0));
    tv.push_back(mk(0, 5'b11111, 5'b00000, 1, lens(1,1,1,1,1), 1, 2, 5'b00100, 1, 0));
    tv.push_back(mk(0, 5'b11111, 5'b00000, 1, lens(1,1,1,1,1), 1, 3, 5'b01000, 1, 0));
    tv.push_back(mk(0, 5'b11111, 5'b00000, 1, lens(1,1,1,1,1), 1, 4, 5'b10000, 1, 0));
    tv.push_back(mk(0, 5'b00001, 5'b00000, 1, lens(1,1,1,1,1), 1, 0, 5'b00001, 1, 0));
    tv.push_back(mk(0, 5'b00001, 5'b00000, 1, lens(1,1,1,1,1), 1, 0, 5'b00001, 1, 0));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 1, lens(1,1,1,1,1), 0, 0, 5'b00000, 0, 0));
    tv.push_back(mk(0, 5'b10100, 5'b00000, 0, lens(1,1,1,1,1), 1, 2, 5'b00000, 1, 0));
    tv.push_back(mk(0, 5'b10100, 5'b00000, 1, lens(1,1,1,1,1), 1, 2, 5'b00100, 1, 0));
    tv.push_back(mk(0, 5'b10001, 5'b00000, 1, lens(1,1,1,1,1), 1, 4, 5'b10000, 1, 0));
    tv.push_back(mk(0, 5'b01000, 5'b00000, 1, lens(1,1,1,0,1), 1, 3, 5'b01000, 1, 0));
    tv.push_back(mk(0, 5'b00011, 5'b00000, 1, lens(1,1,1,1,1), 1, 0, 5'b00001, 1, 0));
    tv.push_back(mk(0, 5'b00011, 5'b00000, 1, lens(1,1,1,1,1), 1, 1, 5'b00010, 1, 0));
    // Burst lock: sub 2 holds the port for 4 beats while sub 3 waits.
    tv.push_back(mk(1, 5'b01100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b01100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b01100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b01100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 1, 0));
    tv.push_back(mk(0, 5'b01000, 5'b00000, 1, lens(1,1,4,1,1), 1, 3, 5'b01000, 1, 0));
    // Backpressure and valid drop mid-burst; sub 0 must not steal the grant.
    tv.push_back(mk(1, 5'b00100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b00101, 5'b00000, 0, lens(1,1,4,1,1), 1, 2, 5'b00000, 0, 0));
    tv.push_back(mk(0, 5'b00001, 5'b00000, 1, lens(1,1,4,1,1), 0, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b00101, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b00101, 5'b00000, 0, lens(1,1,4,1,1), 1, 2, 5'b00000, 0, 0));
    tv.push_back(mk(0, 5'b00101, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 0));
    tv.push_back(mk(0, 5'b00101, 5'b00000, 0, lens(1,1,4,1,1), 1, 2, 5'b00000, 1, 0));
    tv.push_back(mk(0, 5'b00101, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 1, 0));
    tv.push_back(mk(0, 5'b00001, 5'b00000, 1, lens(1,1,4,1,1), 1, 0, 5'b00001, 1, 0));
    // Framing error: early sub_last on beat 2 of 3 is sticky.
    tv.push_back(mk(1, 5'b00010, 5'b00000, 1, lens(1,3,1,1,1), 1, 1, 5'b00010, 0, 0));
    tv.push_back(mk(0, 5'b00010, 5'b00010, 1, lens(1,3,1,1,1), 1, 1, 5'b00010, 0, 0));
    tv.push_back(mk(0, 5'b00010, 5'b00000, 1, lens(1,3,1,1,1), 1, 1, 5'b00010, 1, 1));
    tv.push_back(mk(0, 5'b00000, 5'b00000, 1, lens(1,3,1,1,1), 0, 0, 5'b00000, 0, 1));
    tv.push_back(mk(0, 5'b10000, 5'b10000, 1, lens(1,3,1,1,1), 1, 4, 5'b10000, 1, 1));

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      apply(tv[i]);
    end

    // Asynchronous reset in the middle of a burst with error still set.
    chk("err_before_rst", 192'(protocol_err), 192'(1));
    apply(mk(0, 5'b00100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 1));
    apply(mk(0, 5'b00100, 5'b00000, 1, lens(1,1,4,1,1), 1, 2, 5'b00100, 0, 1));
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("rst_tvalid", 192'(m.tvalid), 192'(0));
    chk("rst_ready", 192'(sub_ready), 192'(0));
    chk("rst_tid", 192'(m.tid), 192'(0));
    chk("rst_tdata", 192'(m.tdata), 192'(0));
    chk("rst_tlast", 192'(m.tlast), 192'(0));
    chk("rst_err_async", 192'(protocol_err), 192'(0));
    chk("rst_ts_async", 192'(timestamp), 192'(0));
    sub_valid = '0;
    @(negedge clk); #1;
    resetn = 1'b1;

    // Timestamp wrap at 2^TW.
    do_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("ts_15", 192'(timestamp), 192'(15));
    @(posedge clk);
    @(negedge clk);
    chk("ts_wrap", 192'(timestamp), 192'(0));

    chk("sb_drained", 192'(sbq.size()), 192'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
